// File: rtl/sw_event_counter_pkg.sv
// Shared types and constants for the switch-latch event counter.
//   cmp_mode_e      : comparison select applied to the captured switch value
//   DB_CYCLES_50MHZ : stable-cycle count giving 10 ms at a 50 MHz clock
package sw_event_counter_pkg;

    typedef enum logic [1:0] {
        MODE_GT  = 2'b00,
        MODE_LT  = 2'b01,
        MODE_EQ  = 2'b10,
        MODE_ANY = 2'b11
    } cmp_mode_e;

    localparam int unsigned DB_CYCLES_50MHZ = 500000;

endpackage

// File: rtl/sw_event_counter_if.sv
// Board-side signal bundle of the event counter.
//   sw_i/btn_i/clr_i/mode_i : switch bank, raw button, counter clear, compare mode
//   led_o/cnt_o/ovf_o/hex_o : captured switches, event count, overflow, segments
// master drives the inputs (board / bench), slave is the counter itself.
interface sw_event_counter_if
    import sw_event_counter_pkg::*;
#(
    parameter int unsigned SW_W  = 10,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned N_HEX = CNT_W / 4
) ();

    logic [SW_W-1:0]    sw_i;
    logic               btn_i;
    logic               clr_i;
    cmp_mode_e          mode_i;
    logic [SW_W-1:0]    led_o;
    logic [CNT_W-1:0]   cnt_o;
    logic               ovf_o;
    logic [7*N_HEX-1:0] hex_o;

    modport master (
        output sw_i, btn_i, clr_i, mode_i,
        input  led_o, cnt_o, ovf_o, hex_o
    );

    modport slave (
        input  sw_i, btn_i, clr_i, mode_i,
        output led_o, cnt_o, ovf_o, hex_o
    );

endinterface

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment pattern (bit 0 = a ... bit 6 = g).
//   nib_i : value to display
//   seg_o : segment drive, 0 = lit
module hex7seg (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (nib_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/sw_event_counter_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, press pulse.
//   clk50_i, rstn_i : clock, async active-low reset
//   btn_i           : raw bouncing button, active-high
//   level_o         : debounced button level
//   press_o         : one-cycle pulse after each 0->1 change of level_o
module btn_debounce
    import sw_event_counter_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_50MHZ
) (
    input  logic clk50_i,
    input  logic rstn_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned     DB_W    = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync_q;
    logic            btn_s;
    logic            level_q;
    logic            level_d;
    logic            press_q;
    logic [DB_W-1:0] db_cnt;

    // A new level is accepted only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk50_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q  <= 1'b0;
            btn_s   <= 1'b0;
            level_q <= 1'b0;
            level_d <= 1'b0;
            press_q <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync_q  <= btn_i;
            btn_s   <= sync_q;
            level_d <= level_q;
            press_q <= level_q & ~level_d;
            if (btn_s == level_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level_q <= btn_s;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/sw_event_counter.sv
// Switch latch and qualified event counter with seven-segment readout.
//   clk50_i, rstn_i : 50 MHz clock, async active-low reset
//   io (slave)      : sw_i/btn_i/clr_i/mode_i in; led_o/cnt_o/ovf_o registered out,
//                     hex_o combinational from cnt_o (active-low segments)
module sw_event_counter
    import sw_event_counter_pkg::*;
#(
    parameter int unsigned SW_W      = 10,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned N_HEX     = CNT_W / 4,
    parameter int unsigned THRESHOLD = 20,
    parameter int unsigned DB_CYCLES = DB_CYCLES_50MHZ,
    parameter int unsigned SATURATE  = 0
) (
    input  logic              clk50_i,
    input  logic              rstn_i,
    sw_event_counter_if.slave io
);

    localparam logic [SW_W-1:0]  THR     = SW_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             btn_level;
    logic             btn_press;
    logic             evt_c;
    logic             hit_c;
    logic [SW_W-1:0]  led_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk50_i (clk50_i),
        .rstn_i  (rstn_i),
        .btn_i   (io.btn_i),
        .level_o (btn_level),
        .press_o (btn_press)
    );

    // A press is only meaningful while the debounced button is down.
    assign evt_c = btn_press & btn_level;

    // Qualification uses the live switch sample, the same one being latched.
    always_comb begin
        hit_c = 1'b0;
        case (io.mode_i)
            MODE_GT:  hit_c = (io.sw_i > THR);
            MODE_LT:  hit_c = (io.sw_i < THR);
            MODE_EQ:  hit_c = (io.sw_i == THR);
            MODE_ANY: hit_c = 1'b1;
        endcase
    end

    // Clear beats a coincident event; the switch capture happens regardless.
    always_ff @(posedge clk50_i or negedge rstn_i) begin
        if (!rstn_i) begin
            led_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (evt_c) begin
                led_q <= io.sw_i;
            end
            if (io.clr_i) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (evt_c && hit_c) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_q <= 1'b1;
                    cnt_q <= (SATURATE != 0) ? CNT_MAX : '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign io.led_o = led_q;
    assign io.cnt_o = cnt_q;
    assign io.ovf_o = ovf_q;

    for (genvar k = 0; k < N_HEX; k++) begin : g_hex
        hex7seg u_hex (
            .nib_i (cnt_q[4*k +: 4]),
            .seg_o (io.hex_o[7*k +: 7])
        );
    end

endmodule

// File: tb/tb_sw_event_counter.sv
// Bench for sw_event_counter: a wrapping and a saturating instance share one
// stimulus stream; both are compared every cycle against a reference model.
module tb_sw_event_counter;
    import sw_event_counter_pkg::*;

    localparam int unsigned SW_W  = 10;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned N_HEX = 2;
    localparam int unsigned THR   = 20;
    localparam int unsigned DB    = 4;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       btn  = 1'b0;
    logic       clr  = 1'b0;
    logic [9:0] sw   = '0;
    logic [1:0] mode = '0;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    sw_event_counter_if #(.SW_W(SW_W), .CNT_W(CNT_W), .N_HEX(N_HEX)) if0 ();
    sw_event_counter_if #(.SW_W(SW_W), .CNT_W(CNT_W), .N_HEX(N_HEX)) if1 ();

    assign if0.sw_i   = sw;
    assign if0.btn_i  = btn;
    assign if0.clr_i  = clr;
    assign if0.mode_i = cmp_mode_e'(mode);
    assign if1.sw_i   = sw;
    assign if1.btn_i  = btn;
    assign if1.clr_i  = clr;
    assign if1.mode_i = cmp_mode_e'(mode);

    sw_event_counter #(
        .SW_W(SW_W), .CNT_W(CNT_W), .N_HEX(N_HEX), .THRESHOLD(THR),
        .DB_CYCLES(DB), .SATURATE(0)
    ) u_wrap (
        .clk50_i (clk),
        .rstn_i  (rstn),
        .io      (if0)
    );

    sw_event_counter #(
        .SW_W(SW_W), .CNT_W(CNT_W), .N_HEX(N_HEX), .THRESHOLD(THR),
        .DB_CYCLES(DB), .SATURATE(1)
    ) u_sat (
        .clk50_i (clk),
        .rstn_i  (rstn),
        .io      (if1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Standard active-high segment map (bit 0 = a); board drives the inverse.
    function automatic logic [6:0] seg_on(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    function automatic logic [13:0] exp_hex(input logic [7:0] c);
        return {~seg_on(c[7:4]), ~seg_on(c[3:0])};
    endfunction

    function automatic bit qual(input logic [9:0] v, input logic [1:0] m);
        case (m)
            2'b00:   return v > 10'(THR);
            2'b01:   return v < 10'(THR);
            2'b10:   return v == 10'(THR);
            default: return 1'b1;
        endcase
    endfunction

    // Reference model: a level flips once the last DB synchronised samples
    // (each two clocks old) all disagree with it; a rise yields a pulse on the
    // next cycle, acted on at the edge after that.
    logic [9:0] m_led [2];
    logic [7:0] m_cnt [2];
    bit         m_ovf [2];
    bit         m_lvl, m_pulse, m_rose, m_all;
    bit         m_q [$];

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                m_led[i] = '0;
                m_cnt[i] = '0;
                m_ovf[i] = 1'b0;
            end
            m_lvl   = 1'b0;
            m_pulse = 1'b0;
            m_rose  = 1'b0;
            m_q     = '{1'b0, 1'b0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_pulse) m_led[i] = sw;
                if (clr) begin
                    m_cnt[i] = '0;
                    m_ovf[i] = 1'b0;
                end else if (m_pulse && qual(sw, mode)) begin
                    if (m_cnt[i] == 8'd255) begin
                        m_ovf[i] = 1'b1;
                        m_cnt[i] = (i == 1) ? 8'd255 : 8'd0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 8'd1;
                    end
                end
            end
            m_pulse = m_rose;
            m_rose  = 1'b0;
            m_q.push_back(btn);
            if (m_q.size() >= DB + 2) begin
                m_all = 1'b1;
                for (int k = 0; k < int'(DB); k++)
                    if (m_q[m_q.size() - 3 - k] == m_lvl) m_all = 1'b0;
                if (m_all) begin
                    m_lvl  = ~m_lvl;
                    m_rose = m_lvl;
                end
            end
            while (m_q.size() > DB + 2) void'(m_q.pop_front());
        end
    end

    // Per-cycle comparison against the model, just after the falling edge.
    initial forever begin
        @(negedge clk);
        #1;
        if (chk_on) begin
            check("wrap_led", 32'(if0.led_o), 32'(m_led[0]));
            check("wrap_cnt", 32'(if0.cnt_o), 32'(m_cnt[0]));
            check("wrap_ovf", 32'(if0.ovf_o), 32'(m_ovf[0]));
            check("wrap_hex", 32'(if0.hex_o), 32'(exp_hex(m_cnt[0])));
            check("sat_led",  32'(if1.led_o), 32'(m_led[1]));
            check("sat_cnt",  32'(if1.cnt_o), 32'(m_cnt[1]));
            check("sat_ovf",  32'(if1.ovf_o), 32'(m_ovf[1]));
            check("sat_hex",  32'(if1.hex_o), 32'(exp_hex(m_cnt[1])));
        end
    end

    task automatic press(input logic [9:0] v, input logic [1:0] m);
        sw   = v;
        mode = m;
        btn  = 1'b1;
        repeat (10) @(negedge clk);
        btn  = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    logic [13:0] hex_zero;
    int unsigned len;

    initial begin
        hex_zero = {2{7'b1000000}};
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk_on = 1'b1;
        check("rst_led", 32'(if0.led_o), 32'd0);
        check("rst_cnt", 32'(if0.cnt_o), 32'd0);
        check("rst_ovf", 32'(if0.ovf_o), 32'd0);
        check("rst_hex", 32'(if0.hex_o), 32'(hex_zero));
        check("rst_hex_sat", 32'(if1.hex_o), 32'(hex_zero));

        // Clean press, mode GT: count lands on the 8th edge after the rise.
        sw = 10'd21; mode = 2'b00; btn = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("lat_pre", 32'(if0.cnt_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_post", 32'(if0.cnt_o), 32'd1);
        check("lat_led", 32'(if0.led_o), 32'd21);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        press(10'd20, 2'b00);
        check("gt_eq_led", 32'(if0.led_o), 32'd20);
        check("gt_eq_cnt", 32'(if0.cnt_o), 32'd1);

        // Bouncing press then bouncing release.
        mode = 2'b11;
        for (int c = 0; c < 20; c++) begin
            btn = ((c / 2) % 2) == 0;
            @(negedge clk);
        end
        btn = 1'b1;
        repeat (12) @(negedge clk);
        check("bounce_press", 32'(if0.cnt_o), 32'd2);
        for (int c = 0; c < 20; c++) begin
            btn = ((c / 2) % 2) != 0;
            @(negedge clk);
        end
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce_release", 32'(if0.cnt_o), 32'd2);

        press(10'd20, 2'b10);
        check("mode_eq", 32'(if0.cnt_o), 32'd3);
        press(10'd5, 2'b01);
        check("mode_lt", 32'(if0.cnt_o), 32'd4);
        press(10'd5, 2'b00);
        check("mode_gt_no", 32'(if0.cnt_o), 32'd4);
        press(10'($urandom), 2'b11);
        check("mode_any", 32'(if0.cnt_o), 32'd5);

        // Fill to all-ones, then one more.
        for (int k = 0; k < 250; k++) press(10'($urandom), 2'b11);
        check("full_wrap", 32'(if0.cnt_o), 32'd255);
        check("full_sat",  32'(if1.cnt_o), 32'd255);
        check("full_ovf",  32'(if0.ovf_o), 32'd0);
        press(10'd3, 2'b11);
        check("wrap_cnt0", 32'(if0.cnt_o), 32'd0);
        check("wrap_ovf1", 32'(if0.ovf_o), 32'd1);
        check("sat_cnt255", 32'(if1.cnt_o), 32'd255);
        check("sat_ovf1",  32'(if1.ovf_o), 32'd1);

        // Clear coinciding with a qualifying pulse.
        for (int k = 0; k < 9; k++) press(10'd100, 2'b11);
        check("pre_clr_cnt", 32'(if0.cnt_o), 32'd9);
        check("pre_clr_ovf", 32'(if0.ovf_o), 32'd1);
        sw = 10'd33; mode = 2'b11; btn = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_cnt", 32'(if0.cnt_o), 32'd0);
        check("clr_ovf", 32'(if0.ovf_o), 32'd0);
        check("clr_led", 32'(if0.led_o), 32'd33);
        check("clr_sat_cnt", 32'(if1.cnt_o), 32'd0);
        check("clr_sat_ovf", 32'(if1.ovf_o), 32'd0);
        repeat (6) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        check("clr_lost", 32'(if0.cnt_o), 32'd0);

        // Reset in the middle of a debounce with the button held down.
        sw = 10'd7; mode = 2'b11; btn = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("rstdb_pre", 32'(if0.cnt_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstdb_post", 32'(if0.cnt_o), 32'd1);
        check("rstdb_led", 32'(if0.led_o), 32'd7);
        btn = 1'b0;
        repeat (10) @(negedge clk);

        // Random bouncing, switches, modes, clears and resets.
        for (int r = 0; r < 400; r++) begin
            btn = ~btn;
            len = $urandom_range(1, 12);
            for (int j = 0; j < int'(len); j++) begin
                sw   = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(17, 23)) : 10'($urandom);
                mode = 2'($urandom_range(0, 3));
                clr  = ($urandom_range(0, 39) == 0);
                rstn = ($urandom_range(0, 299) != 0);
                @(negedge clk);
            end
        end
        rstn = 1'b1;
        clr  = 1'b0;
        btn  = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
